window_fetch_scheduler: RTL
===========================

// Module: window_fetch_scheduler
// PURPOSE
//  Sequences 3x3 neighbourhood reads from the parallel-read pixel memory over a full frame.
//  - Raster-scans the window top-left (x,y) over every fully interior position.
//  - Issues one base address per window to the memory, waits the read latency, then presents
//    the window to the downstream filter with a valid/ready handshake.
//  - Sits between the frame-level start/done control and the 9-output pixel memory.
// PARAMETERS
//  IMG_W   86  image width in pixels (>=3)
//  IMG_H   102 image height in pixels (>=3)
//  ADDR_W  14  memory address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
//  RD_LAT  1   cycles from mem_rd_en to the 9 pixels being valid (>=1)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       frame start request; sampled in IDLE only
//  abort      in   1       terminate the current frame; sampled while busy
//  busy       out  1       high from the cycle after start is accepted until done
//  done       out  1       one-cycle pulse at frame end (normal or aborted)
//  aborted    out  1       qualifies done: 1 = frame was aborted
//  mem_rd_en  out  1       memory read strobe, one cycle per window
//  mem_addr   out  ADDR_W  window top-left address = y*IMG_W + x
//  win_valid  out  1       memory pixel outputs hold the window at (win_x,win_y)
//  win_ready  in   1       downstream accepts the window
//  win_x      out  8       window top-left column, 0..IMG_W-3
//  win_y      out  8       window top-left row, 0..IMG_H-3
//  win_last   out  1       high with win_valid on the final window of the frame
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, aborted, mem_rd_en, win_valid, win_last = 0;
//    mem_addr, win_x, win_y = 0. Reset overrides every input in the same cycle.
//  FSM states: IDLE, ISSUE, WAIT, PRESENT, FIN.
//   IDLE: start=1 -> ISSUE; x=y=0, addr=0. All other inputs are ignored.
//   ISSUE (1 cycle): mem_rd_en=1 with mem_addr valid.
//     RD_LAT=1 -> PRESENT. RD_LAT>1 -> WAIT, counter loaded with RD_LAT-1.
//   WAIT: the counter decrements each cycle; on reaching 0 -> PRESENT.
//   PRESENT: win_valid=1. win_x, win_y and mem_addr are held stable until win_valid&win_ready.
//     On that handshake, if not last: advance and go to ISSUE. If last: go to FIN.
//   FIN (1 cycle): done=1, busy=0 -> IDLE.
//  Advance rules, incremental with no multiplier:
//   - x<IMG_W-3: x+1, addr+1.
//   - x=IMG_W-3: x=0, y+1, addr+3 (skips the 2 right-border columns).
//   - win_last = (x==IMG_W-3)&&(y==IMG_H-3).
//  Timing: mem_rd_en at cycle t gives win_valid from cycle t+RD_LAT.
//    Peak throughput is 1 window per RD_LAT+1 cycles.
//  Window count per frame is (IMG_W-2)*(IMG_H-2), which is 8400 at the defaults.
//  abort: in any non-IDLE, non-FIN state, abort=1 -> FIN next cycle with aborted=1.
//   - win_valid and mem_rd_en drop immediately; no partial handshake is counted.
//   - abort wins over a same-cycle win_ready.
//  start while busy is ignored (no queueing). start and abort together in IDLE: start wins.
//  aborted is held until the next accepted start, then cleared to 0.
//  win_valid never deasserts without a handshake, except on abort or reset.
// TESTING
//  1. Defaults, win_ready=1, pulse start:
//     -> 8400 handshakes; first mem_addr=0; last mem_addr=8597 (x=83,y=99) with win_last=1;
//        done=1, aborted=0 one cycle later.
//  2. Row wrap: at window x=83,y=0 (addr 83), handshake -> next mem_addr=86, win_x=0, win_y=1.
//  3. Backpressure: hold win_ready=0 for 5 cycles in PRESENT
//     -> win_valid, mem_addr and win_x/win_y stable; no new mem_rd_en; resumes on ready.
//  4. RD_LAT=3: mem_rd_en at cycle t -> win_valid first high at t+3;
//     with ready=1, rd_en period is 4 cycles.
//  5. abort asserted on the 10th window together with win_ready=1
//     -> next cycle done=1, aborted=1, win_valid=0; start=1 during busy ignored.
//  6. rst=1 mid-frame (y=5) -> next cycle all outputs 0, IDLE;
//     a fresh start restarts at mem_addr=0.

Source files
------------

// File: rtl/window_fetch_scheduler.sv
// Raster-scans a 3x3 window over every interior position of a frame, issuing one
// base address per window to the parallel-read pixel memory and presenting the result downstream.
module window_fetch_scheduler #(
  parameter int IMG_W  = 86,
  parameter int IMG_H  = 102,
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [7:0]        win_x,
  output logic [7:0]        win_y,
  output logic              win_last,
  output logic [2:0]        fsm_state
);

  // Handshake: a window transfers on any cycle where win_valid && win_ready are both high;
  // win_valid, win_x, win_y and mem_addr stay stable until then, unless abort or reset.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [7:0] X_LAST = 8'(IMG_W - 3);
  localparam logic [7:0] Y_LAST = 8'(IMG_H - 3);

  state_t            state, state_n;
  logic [7:0]        x, x_n, y, y_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              aborted_q, aborted_n;
  logic              last;

  assign last = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      cnt       <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_n;
      x         <= x_n;
      y         <= y_n;
      addr      <= addr_n;
      cnt       <= cnt_n;
      aborted_q <= aborted_n;
    end
  end

  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    addr_n    = addr;
    cnt_n     = cnt;
    aborted_n = aborted_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n   = S_ISSUE;
          x_n       = '0;
          y_n       = '0;
          addr_n    = '0;
          aborted_n = 1'b0;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_n   = S_FIN;
          aborted_n = 1'b1;
        end else if (RD_LAT == 1) begin
          state_n = S_PRESENT;
        end else begin
          state_n = S_WAIT;
          cnt_n   = CNT_W'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_n   = S_FIN;
          aborted_n = 1'b1;
        end else if (cnt <= CNT_W'(1)) begin
          state_n = S_PRESENT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_PRESENT: begin
        if (abort) begin
          state_n   = S_FIN;
          aborted_n = 1'b1;
        end else if (win_ready) begin
          if (last) begin
            state_n = S_FIN;
          end else begin
            state_n = S_ISSUE;
            // Row wrap jumps over the two right-border columns with no multiply.
            if (x == X_LAST) begin
              x_n    = '0;
              y_n    = y + 8'd1;
              addr_n = addr + ADDR_W'(3);
            end else begin
              x_n    = x + 8'd1;
              addr_n = addr + ADDR_W'(1);
            end
          end
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_PRESENT);
  assign done      = (state == S_FIN);
  assign aborted   = aborted_q;
  assign mem_rd_en = (state == S_ISSUE);
  assign win_valid = (state == S_PRESENT);
  assign win_last  = win_valid && last;
  assign mem_addr  = addr;
  assign win_x     = x;
  assign win_y     = y;
  assign fsm_state = state;

endmodule
